// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions: FSM state encodings and default memory depth,
// used by the fetch unit and the controller.
package fetch_unit_pkg;

  // Fetch FSM states; encodings are visible to the controller.
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } cpu_state_e;

  // Default number of valid instruction words in instruction memory.
  localparam int DEFAULT_ROM_DEPTH = 10;

  // True when a word address (33 bits so PC + 1 cannot wrap) lies inside
  // the instruction memory.
  function automatic logic addr_in_rom(input logic [32:0] addr,
                                       input int          depth);
    return addr < 33'(depth);
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC selection for the fetch unit.
// Priority: halt > stall > branch > sequential increment. Any redirect or
// step that would leave instruction memory holds the PC and flags it.
module next_pc_sel
  import fetch_unit_pkg::*;
#(
  parameter int ROM_DEPTH = DEFAULT_ROM_DEPTH
) (
  input  logic [31:0] pc,
  input  logic        halt_req,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] next_pc,
  output logic        out_of_range
);

  logic [32:0] seq_pc;

  // Unsigned step evaluated one bit wider so the PC can never wrap to 0.
  assign seq_pc = {1'b0, pc} + 33'd1;

  // Pick the next fetch address and detect out-of-memory targets.
  always_comb begin
    next_pc      = pc;
    out_of_range = 1'b0;
    if (halt_req || stall) begin
      next_pc = pc;
    end else if (branch_taken) begin
      if (addr_in_rom({1'b0, branch_target}, ROM_DEPTH)) begin
        next_pc = branch_target;
      end else begin
        out_of_range = 1'b1;
      end
    end else begin
      if (addr_in_rom(seq_pc, ROM_DEPTH)) begin
        next_pc = seq_pc[31:0];
      end else begin
        out_of_range = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, RUN/HALTED/FAULT state machine and
// a saturating count of issued instructions. The address goes straight to
// instruction memory and the returned word is forwarded while running.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ROM_DEPTH = DEFAULT_ROM_DEPTH,
  parameter int CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             BranchTaken,
  input  logic [31:0]      BranchTarget,
  input  logic             HaltReq,
  input  logic [31:0]      InsIn,
  output logic [31:0]      AddrOut,
  output logic [31:0]      InsOut,
  output logic             Valid,
  output logic             Halted,
  output logic             Fault,
  output logic [CNT_W-1:0] FetchCnt
);

  cpu_state_e       state_reg, state_next;
  logic [31:0]      pc_reg, pc_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             halted_reg, fault_reg;

  logic [31:0]      sel_pc;
  logic             sel_out_of_range;

  next_pc_sel #(
    .ROM_DEPTH (ROM_DEPTH)
  ) u_next_pc_sel (
    .pc            (pc_reg),
    .halt_req      (HaltReq),
    .stall         (Stall),
    .branch_taken  (BranchTaken),
    .branch_target (BranchTarget),
    .next_pc       (sel_pc),
    .out_of_range  (sel_out_of_range)
  );

  // Next state, next PC and next count; HALTED and FAULT hold everything.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    cnt_next   = cnt_reg;
    if (state_reg == ST_RUN) begin
      if (HaltReq) begin
        state_next = ST_HALTED;
      end else begin
        if (!Stall && !(&cnt_reg)) begin
          cnt_next = cnt_reg + 1'b1;
        end
        if (sel_out_of_range) begin
          state_next = ST_FAULT;
        end else begin
          pc_next = sel_pc;
        end
      end
    end
  end

  // State, PC, counter and decoded status flags; reset discards any
  // pending redirect because the next-PC path is simply not loaded.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg  <= ST_RUN;
      pc_reg     <= 32'd0;
      cnt_reg    <= '0;
      halted_reg <= 1'b0;
      fault_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      cnt_reg    <= cnt_next;
      halted_reg <= (state_next == ST_HALTED);
      fault_reg  <= (state_next == ST_FAULT);
    end
  end

  assign AddrOut  = pc_reg;
  assign Valid    = (state_reg == ST_RUN);
  assign InsOut   = Valid ? InsIn : 32'h0000_0000;
  assign Halted   = halted_reg;
  assign Fault    = fault_reg;
  assign FetchCnt = cnt_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: sequential run, branch/stall,
// boundary faults, halt and reset recovery.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        halt_req;
  logic [31:0] ins_in;
  logic [31:0] addr_out;
  logic [31:0] ins_out;
  logic        valid;
  logic        halted;
  logic        fault;
  logic [15:0] fetch_cnt;

  int n_cmp;
  int n_bad;

  fetch_unit #(
    .ROM_DEPTH (10),
    .CNT_W     (16)
  ) dut (
    .Clk          (clk),
    .Reset        (reset),
    .Stall        (stall),
    .BranchTaken  (branch_taken),
    .BranchTarget (branch_target),
    .HaltReq      (halt_req),
    .InsIn        (ins_in),
    .AddrOut      (addr_out),
    .InsOut       (ins_out),
    .Valid        (valid),
    .Halted       (halted),
    .Fault        (fault),
    .FetchCnt     (fetch_cnt)
  );

  // Instruction memory stand-in: word tagged with its address.
  assign ins_in = 32'hA000_0000 | addr_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'd0;
    halt_req      = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    idle_inputs();

    // Reset state
    do_reset();
    check("rst_addr",   addr_out,  0);
    check("rst_valid",  valid,     1);
    check("rst_halted", halted,    0);
    check("rst_fault",  fault,     0);
    check("rst_cnt",    fetch_cnt, 0);
    check("rst_ins",    ins_out,   64'hA000_0000);
    $display("reset: addr=%0d cnt=%0d", addr_out, fetch_cnt);

    // Sequential run of 5 cycles
    for (int i = 1; i <= 5; i++) begin
      step();
      check("seq_addr",  addr_out, i);
      check("seq_valid", valid,    1);
      $display("seq step %0d: addr=%0d ins=%08h", i, addr_out, ins_out);
    end
    check("seq_cnt", fetch_cnt, 5);
    check("seq_ins", ins_out,   64'hA000_0005);

    // Branch with simultaneous stall holds, then branch to 2, then step to 3
    do_reset();
    for (int i = 0; i < 4; i++) step();
    check("br_pre_addr", addr_out, 4);
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'd2;
    step();
    check("br_stall_addr", addr_out, 4);
    $display("branch+stall: addr=%0d", addr_out);
    stall = 1'b0;
    step();
    check("br_addr", addr_out, 2);
    $display("branch: addr=%0d", addr_out);
    idle_inputs();
    step();
    check("br_next_addr", addr_out, 3);
    check("br_cnt",       fetch_cnt, 6);
    $display("after branch: addr=%0d cnt=%0d", addr_out, fetch_cnt);

    // Run off the end of memory: 3 -> 9, then fault
    for (int i = 0; i < 6; i++) step();
    check("bnd_pre_addr", addr_out, 9);
    check("bnd_pre_cnt",  fetch_cnt, 12);
    step();
    check("bnd_fault",  fault,     1);
    check("bnd_valid",  valid,     0);
    check("bnd_ins",    ins_out,   0);
    check("bnd_addr",   addr_out,  9);
    check("bnd_halted", halted,    0);
    check("bnd_cnt",    fetch_cnt, 13);
    $display("boundary: fault=%0d addr=%0d cnt=%0d", fault, addr_out, fetch_cnt);
    // FAULT absorbs further inputs
    branch_taken = 1'b1; branch_target = 32'd1;
    step();
    halt_req = 1'b1;
    step();
    idle_inputs();
    check("flt_abs_fault",  fault,     1);
    check("flt_abs_halted", halted,    0);
    check("flt_abs_addr",   addr_out,  9);
    check("flt_abs_cnt",    fetch_cnt, 13);
    $display("fault absorbing: addr=%0d cnt=%0d", addr_out, fetch_cnt);

    // Reset recovery from FAULT
    do_reset();
    check("rec_flt_addr",   addr_out,  0);
    check("rec_flt_fault",  fault,     0);
    check("rec_flt_halted", halted,    0);
    check("rec_flt_cnt",    fetch_cnt, 0);
    check("rec_flt_valid",  valid,     1);
    $display("recover from fault: addr=%0d fault=%0d", addr_out, fault);

    // Branch out of range from PC=3
    for (int i = 0; i < 3; i++) step();
    branch_taken = 1'b1; branch_target = 32'd10;
    step();
    idle_inputs();
    check("obr_fault", fault,     1);
    check("obr_addr",  addr_out,  3);
    check("obr_valid", valid,     0);
    check("obr_cnt",   fetch_cnt, 4);
    $display("branch to 10: fault=%0d addr=%0d", fault, addr_out);

    // Halt at PC=9 with a simultaneous branch
    do_reset();
    for (int i = 0; i < 9; i++) step();
    check("hlt_pre_addr", addr_out, 9);
    halt_req = 1'b1; branch_taken = 1'b1; branch_target = 32'd2;
    step();
    check("hlt_halted", halted,    1);
    check("hlt_fault",  fault,     0);
    check("hlt_addr",   addr_out,  9);
    check("hlt_cnt",    fetch_cnt, 9);
    check("hlt_valid",  valid,     0);
    check("hlt_ins",    ins_out,   0);
    $display("halt: halted=%0d addr=%0d cnt=%0d", halted, addr_out, fetch_cnt);
    halt_req = 1'b0;
    step();
    branch_taken = 1'b0;
    step();
    check("hlt_abs_halted", halted,    1);
    check("hlt_abs_addr",   addr_out,  9);
    check("hlt_abs_cnt",    fetch_cnt, 9);
    $display("halt absorbing: addr=%0d cnt=%0d", addr_out, fetch_cnt);
    idle_inputs();

    // Reset during a stall with a pending branch discards the redirect
    do_reset();
    step();
    step();
    check("rst_stl_pre", addr_out, 2);
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'd5;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_stl_addr",   addr_out,  0);
    check("rst_stl_cnt",    fetch_cnt, 0);
    check("rst_stl_halted", halted,    0);
    check("rst_stl_fault",  fault,     0);
    idle_inputs();
    step();
    check("rst_stl_next", addr_out, 1);
    $display("reset mid-stall: addr=%0d cnt=%0d", addr_out, fetch_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL provide parameter ROM_DEPTH, default 10, giving the number of valid instruction words in instruction memory.
REQ-002 The module SHALL provide parameter CNT_W, default 16, giving the width of the fetch counter.
REQ-003 The module SHALL provide port Clk  input  1  system clock; all state updates occur on its rising edge.
REQ-004 The module SHALL provide port Reset  input  1  synchronous, active-high reset.
REQ-005 The module SHALL provide port Stall  input  1  hold PC this cycle.
REQ-006 The module SHALL provide port BranchTaken  input  1  redirect the next PC to BranchTarget.
REQ-007 The module SHALL provide port BranchTarget  input  32  word-indexed redirect address.
REQ-008 The module SHALL provide port HaltReq  input  1  controller has decoded a halt instruction.
REQ-009 The module SHALL provide port InsIn  input  32  instruction word returned by instruction memory.
REQ-010 The module SHALL provide port AddrOut  output  32  word-indexed fetch address to instruction memory (equals PC).
REQ-011 The module SHALL provide port InsOut  output  32  instruction to the controller, register file and immediate generator.
REQ-012 The module SHALL provide port Valid  output  1  InsOut is a live instruction.
REQ-013 The module SHALL provide port Halted  output  1  the unit is in HALTED.
REQ-014 The module SHALL provide port Fault  output  1  the unit is in FAULT.
REQ-015 The module SHALL provide port FetchCnt  output  CNT_W  count of instructions issued since reset.

Function
REQ-016 The module SHALL use word addressing: sequential next PC = PC + 1.
REQ-017 The FSM SHALL have three states: RUN, HALTED, FAULT.
REQ-018 In RUN, the next-PC priority SHALL be HaltReq > Stall > BranchTaken > increment.
REQ-019 In RUN with HaltReq=1, the FSM SHALL go to HALTED and the PC SHALL hold.
REQ-020 In RUN with Stall=1 and HaltReq=0, the PC SHALL hold and state SHALL remain RUN.
REQ-021 In RUN with BranchTaken=1 and no halt or stall, the next PC SHALL be BranchTarget if BranchTarget < ROM_DEPTH; otherwise the FSM SHALL go to FAULT with the PC held.
REQ-022 In RUN on a sequential step, the FSM SHALL go to FAULT with the PC held if PC + 1 >= ROM_DEPTH; the comparison is unsigned 32-bit, and the PC never wraps.
REQ-023 HALTED and FAULT SHALL be absorbing; only Reset exits them, and all inputs are ignored.
REQ-024 Valid SHALL be 1 only in RUN; InsOut SHALL equal InsIn combinationally when Valid=1, else 32'h00000000.
REQ-025 AddrOut SHALL always equal the registered PC; it has zero-cycle latency to instruction memory.
REQ-026 FetchCnt SHALL increment by 1 on each RUN cycle with HaltReq=0 and Stall=0, saturating at all-ones.
REQ-027 Halted and Fault SHALL be registered outputs decoded from the state.

Reset
REQ-028 When Reset=1 at a rising edge, the PC SHALL become 0, the state RUN and FetchCnt 0, regardless of current state or other inputs.
REQ-029 After reset the outputs SHALL be AddrOut=0, Valid=1, Halted=0, Fault=0, FetchCnt=0, and InsOut=InsIn.
REQ-030 Reset asserted mid-stall or mid-branch SHALL discard the pending redirect.

Structure
REQ-031 State encodings (RUN=2'd0, HALTED=2'd1, FAULT=2'd2) and the default ROM_DEPTH constant SHALL live in a shared CPU package also used by the controller.
REQ-032 The next-PC selection SHALL be a combinational sub-module named next_pc_sel; the PC register, FSM and counter stay in fetch_unit.

Verification
REQ-033 Sequential run: release Reset, no other inputs for 5 cycles -> AddrOut 0,1,2,3,4,5; FetchCnt=5; Valid=1 throughout.
REQ-034 Branch: at PC=4 assert BranchTaken with BranchTarget=2 for one cycle -> next AddrOut=2, then 3; a simultaneous Stall=1 instead holds AddrOut=4.
REQ-035 Boundary: run to PC=9 with ROM_DEPTH=10 -> next edge gives Fault=1, Valid=0, InsOut=0, AddrOut=9; a branch to 10 from PC=3 also gives Fault=1 with AddrOut=3.
REQ-036 Halt: at PC=9 assert HaltReq=1 together with BranchTaken=1 -> Halted=1, AddrOut=9, FetchCnt frozen, and later inputs are ignored.
REQ-037 Reset recovery: from FAULT, and separately during a Stall, assert Reset for one cycle -> AddrOut=0, state RUN, FetchCnt=0, Fault=0, Halted=0.
